// File: rtl/cmos_frame_ctrl.sv
// Frame capture controller: arms/stops capture, aligns to vsync, addresses pixels into a
// two-bank ping-pong buffer and publishes complete frames. Optional checking: CMOS_FRAME_CTRL_ERR_CHK_EN.
module cmos_frame_ctrl #(
  parameter int H_PIXEL = 640,
  parameter int V_PIXEL = 480,
  parameter int ADDR_W  = 19
) (
  input  logic              cam_pclk,
  input  logic              rst,
  input  logic              cap_start,
  input  logic              cap_mode,
  input  logic              cap_stop,
  input  logic              cmos_frame_vsync,
  input  logic              cmos_frame_href,
  input  logic              cmos_frame_valid,
  input  logic [15:0]       cmos_frame_data,
  input  logic              rd_release,
  input  logic              rd_rel_bank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_bank,
  output logic              frame_done,
  output logic              rd_bank,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] FRAME_PIX_C = IDX_W'(H_PIXEL * V_PIXEL);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_CAPT = 3'd2,
    S_END  = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               vsync_q;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic [1:0]         bank_busy_q, bank_busy_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic               wr_bank_q, wr_bank_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  logic               rd_bank_q, rd_bank_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               busy_q;
  logic               vs_edge_s;
  logic               launch_s;
  logic               frame_good_s;
  logic               free_bank_s;

`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
  logic               href_q;
  logic               href_fall_s;
  logic               ovf_q, ovf_d;
  logic               line_err_q, line_err_d;
  logic [15:0]        line_pix_q, line_pix_d;
  logic [15:0]        line_cnt_q, line_cnt_d;
  logic [15:0]        line_pix_now_s;

  assign href_fall_s = href_q & ~cmos_frame_href;
`else
  logic               unused_href_s;

  assign unused_href_s = cmos_frame_href;
`endif

  assign vs_edge_s   = cmos_frame_vsync & ~vsync_q;
  assign free_bank_s = ~rd_bank_q;

  // Next-state, write-path and publish decisions.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    pix_idx_d    = pix_idx_q;
    bank_busy_d  = bank_busy_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_bank_d    = wr_bank_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    rd_bank_d    = rd_bank_q;
    frame_cnt_d  = frame_cnt_q;
    launch_s     = 1'b0;
    frame_good_s = 1'b1;
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
    ovf_d          = ovf_q;
    line_err_d     = line_err_q;
    line_pix_d     = line_pix_q;
    line_cnt_d     = line_cnt_q;
    line_pix_now_s = line_pix_q;
`endif

    if (rd_release) begin
      bank_busy_d[rd_rel_bank] = 1'b0;
    end else begin
      bank_busy_d = bank_busy_q;
    end

    if (cap_stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cap_start) begin
            state_d = S_ARM;
            mode_d  = cap_mode;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ARM: begin
          launch_s = vs_edge_s;
        end
        S_CAPT: begin
          if (cmos_frame_valid && (pix_idx_q < FRAME_PIX_C)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pix_idx_q[ADDR_W-1:0];
            wr_data_d = cmos_frame_data;
            pix_idx_d = pix_idx_q + IDX_W'(1);
          end else if (cmos_frame_valid) begin
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
            ovf_d = 1'b1;
`else
            pix_idx_d = pix_idx_q;
`endif
          end else begin
            pix_idx_d = pix_idx_q;
          end
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
          // A strobe coinciding with the href fall still belongs to the ending line.
          if (cmos_frame_valid && (line_pix_q != 16'hFFFF)) begin
            line_pix_now_s = line_pix_q + 16'd1;
          end else begin
            line_pix_now_s = line_pix_q;
          end
          if (href_fall_s) begin
            line_pix_d = 16'd0;
            if (line_pix_now_s != 16'(H_PIXEL)) begin
              line_err_d = 1'b1;
            end else begin
              line_err_d = line_err_q;
            end
            if (line_cnt_q != 16'hFFFF) begin
              line_cnt_d = line_cnt_q + 16'd1;
            end else begin
              line_cnt_d = line_cnt_q;
            end
          end else begin
            line_pix_d = line_pix_now_s;
          end
          frame_good_s = ~line_err_d && (line_cnt_d == 16'(V_PIXEL)) && ~ovf_d;
`endif
          if (vs_edge_s) begin
            state_d = S_END;
            if (frame_good_s) begin
              frame_done_d           = 1'b1;
              rd_bank_d              = wr_bank_q;
              bank_busy_d[wr_bank_q] = 1'b1;
              frame_cnt_d            = frame_cnt_q + 16'd1;
            end else begin
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
              frame_err_d = 1'b1;
`else
              frame_err_d = 1'b0;
`endif
            end
          end else begin
            state_d = S_CAPT;
          end
        end
        S_END: begin
          if (mode_q) begin
            launch_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HOLD: begin
          if (rd_release && (rd_rel_bank == free_bank_s)) begin
            state_d = S_ARM;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      // rd_bank_q already reflects the frame just published when leaving END.
      if (launch_s) begin
        if (bank_busy_q[free_bank_s]) begin
          state_d = S_HOLD;
        end else begin
          state_d   = S_CAPT;
          wr_bank_d = free_bank_s;
          pix_idx_d = '0;
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
          ovf_d      = 1'b0;
          line_err_d = 1'b0;
          line_pix_d = 16'd0;
          line_cnt_d = 16'd0;
`endif
        end
      end else begin
        wr_bank_d = wr_bank_q;
      end
    end
  end

  // State, counters and registered write/status outputs.
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      vsync_q      <= 1'b0;
      pix_idx_q    <= '0;
      bank_busy_q  <= 2'b00;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 16'd0;
      wr_bank_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_bank_q    <= 1'b1;
      frame_cnt_q  <= 16'd0;
      busy_q       <= 1'b0;
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
      href_q       <= 1'b0;
      ovf_q        <= 1'b0;
      line_err_q   <= 1'b0;
      line_pix_q   <= 16'd0;
      line_cnt_q   <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      vsync_q      <= cmos_frame_vsync;
      pix_idx_q    <= pix_idx_d;
      bank_busy_q  <= bank_busy_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_bank_q    <= wr_bank_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      rd_bank_q    <= rd_bank_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= (state_d != S_IDLE);
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
      href_q       <= cmos_frame_href;
      ovf_q        <= ovf_d;
      line_err_q   <= line_err_d;
      line_pix_q   <= line_pix_d;
      line_cnt_q   <= line_cnt_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_bank    = wr_bank_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign rd_bank    = rd_bank_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cmos_frame_ctrl.sv
// Directed bench for cmos_frame_ctrl on a 4x2 frame: a vector table for the basic single-frame
// capture plus hand-written sequences for ping-pong, hold, errors, stop and reset.
module tb_cmos_frame_ctrl;

  localparam int H = 4;
  localparam int V = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cap_start = 1'b0;
  logic          cap_mode = 1'b0;
  logic          cap_stop = 1'b0;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic          valid = 1'b0;
  logic [15:0]   data = 16'd0;
  logic          rd_release = 1'b0;
  logic          rd_rel_bank = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_bank;
  logic          frame_done;
  logic          rd_bank;
  logic          busy;
  logic          frame_err;
  logic [15:0]   frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_idx = 0;

  typedef struct {
    logic        start, mode, stop, vs, hr, vl;
    logic [15:0] din;
    logic        en;
    logic [3:0]  addr;
    logic        bank, done, err, rdb, bsy;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  cmos_frame_ctrl #(.H_PIXEL(H), .V_PIXEL(V), .ADDR_W(AW)) dut (
    .cam_pclk(clk), .rst(rst), .cap_start(cap_start), .cap_mode(cap_mode), .cap_stop(cap_stop),
    .cmos_frame_vsync(vsync), .cmos_frame_href(href), .cmos_frame_valid(valid),
    .cmos_frame_data(data), .rd_release(rd_release), .rd_rel_bank(rd_rel_bank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
    .frame_done(frame_done), .rd_bank(rd_bank), .busy(busy), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic md, logic sp, logic vs, logic hr, logic vl,
                              logic [15:0] din, logic en, logic [3:0] addr, logic bank,
                              logic done, logic err, logic rdb, logic bsy, logic [15:0] cnt);
    vec_t v;
    v.start = st; v.mode = md; v.stop = sp; v.vs = vs; v.hr = hr; v.vl = vl; v.din = din;
    v.en = en; v.addr = addr; v.bank = bank; v.done = done; v.err = err; v.rdb = rdb;
    v.bsy = bsy; v.cnt = cnt;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_wr_en"}, wr_en, 1'b0);
    chk16({tag, "_wr_addr"}, 16'(wr_addr), 16'd0);
    chk16({tag, "_wr_data"}, wr_data, 16'd0);
    chk1({tag, "_wr_bank"}, wr_bank, 1'b0);
    chk1({tag, "_done"}, frame_done, 1'b0);
    chk1({tag, "_err"}, frame_err, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_rd_bank"}, rd_bank, 1'b1);
    chk16({tag, "_cnt"}, frame_cnt, 16'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start(input logic md);
    cap_start = 1'b1;
    cap_mode  = md;
    tick();
    cap_start = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  // One line of n pixels followed by one href-low cycle; writes expected only below H*V.
  task automatic pix_line(input string tag, input int n, input logic exp_wr, input logic bank);
    href = 1'b1;
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      data  = 16'h5000 + 16'(exp_idx);
      tick();
      if (exp_wr && (exp_idx < H * V)) begin
        chk1($sformatf("%s_p%0d_en", tag, exp_idx), wr_en, 1'b1);
        chk16($sformatf("%s_p%0d_addr", tag, exp_idx), 16'(wr_addr), 16'(exp_idx));
        chk16($sformatf("%s_p%0d_data", tag, exp_idx), wr_data, 16'h5000 + 16'(exp_idx));
        chk1($sformatf("%s_p%0d_bank", tag, exp_idx), wr_bank, bank);
      end else begin
        chk1($sformatf("%s_p%0d_noen", tag, exp_idx), wr_en, 1'b0);
      end
      exp_idx++;
    end
    valid = 1'b0;
    href  = 1'b0;
    tick();
    chk1({tag, "_eol_en"}, wr_en, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Single-mode 4x2 frame: start, vsync, 2 lines of 4, vsync, then an ignored idle pixel.
    tbl.push_back(mk(1,0,0, 0,0,0, 16'h0000, 0,4'd0,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 1,0,0, 16'h0000, 0,4'd0,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hC000, 1,4'd0,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hC001, 1,4'd1,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hC002, 1,4'd2,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hC003, 1,4'd3,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,0,0, 16'h0000, 0,4'd3,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hC004, 1,4'd4,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hC005, 1,4'd5,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hC006, 1,4'd6,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hC007, 1,4'd7,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 0,0,0, 16'h0000, 0,4'd7,0, 0,0,1,1, 16'd0));
    tbl.push_back(mk(0,0,0, 1,0,0, 16'h0000, 0,4'd7,0, 1,0,0,1, 16'd1));
    tbl.push_back(mk(0,0,0, 0,0,0, 16'h0000, 0,4'd7,0, 0,0,0,0, 16'd1));
    tbl.push_back(mk(0,0,0, 0,1,1, 16'hDEAD, 0,4'd7,0, 0,0,0,0, 16'd1));

    do_reset();
    chk_reset("rst0");

    for (int i = 0; i < tbl.size(); i++) begin
      cap_start = tbl[i].start; cap_mode = tbl[i].mode; cap_stop = tbl[i].stop;
      vsync = tbl[i].vs; href = tbl[i].hr; valid = tbl[i].vl; data = tbl[i].din;
      tick();
      chk1($sformatf("t%0d_en", i), wr_en, tbl[i].en);
      if (tbl[i].en) begin
        chk16($sformatf("t%0d_addr", i), 16'(wr_addr), 16'(tbl[i].addr));
        chk16($sformatf("t%0d_data", i), wr_data, tbl[i].din);
      end
      chk1($sformatf("t%0d_bank", i), wr_bank, tbl[i].bank);
      chk1($sformatf("t%0d_done", i), frame_done, tbl[i].done);
      chk1($sformatf("t%0d_err", i), frame_err, tbl[i].err);
      chk1($sformatf("t%0d_rdb", i), rd_bank, tbl[i].rdb);
      chk1($sformatf("t%0d_busy", i), busy, tbl[i].bsy);
      chk16($sformatf("t%0d_cnt", i), frame_cnt, tbl[i].cnt);
    end
    cap_start = 1'b0; vsync = 1'b0; href = 1'b0; valid = 1'b0;
    tick();

    // Continuous ping-pong without releases, then HOLD and release of bank 0.
    do_reset();
    start(1'b1);
    vs_pulse();
    chk1("c_f1_bank", wr_bank, 1'b0);
    exp_idx = 0;
    pix_line("c_f1l0", 4, 1'b1, 1'b0);
    pix_line("c_f1l1", 4, 1'b1, 1'b0);
    vs_pulse();
    chk1("c_f1_done", frame_done, 1'b1);
    chk1("c_f1_rdb", rd_bank, 1'b0);
    chk16("c_f1_cnt", frame_cnt, 16'd1);
    tick();
    chk1("c_f1_done_off", frame_done, 1'b0);
    chk1("c_f2_bank", wr_bank, 1'b1);
    exp_idx = 0;
    pix_line("c_f2l0", 4, 1'b1, 1'b1);
    pix_line("c_f2l1", 4, 1'b1, 1'b1);
    vs_pulse();
    chk1("c_f2_done", frame_done, 1'b1);
    chk1("c_f2_rdb", rd_bank, 1'b1);
    chk16("c_f2_cnt", frame_cnt, 16'd2);
    tick();
    chk1("c_hold_busy", busy, 1'b1);
    exp_idx = 0;
    pix_line("c_hold_l0", 4, 1'b0, 1'b0);
    pix_line("c_hold_l1", 4, 1'b0, 1'b0);
    vs_pulse();
    chk1("c_hold_done", frame_done, 1'b0);
    chk1("c_hold_err", frame_err, 1'b0);
    chk16("c_hold_cnt", frame_cnt, 16'd2);
    tick();
    rd_release = 1'b1; rd_rel_bank = 1'b0;
    tick();
    rd_release = 1'b0;
    vs_pulse();
    chk1("c_f3_bank", wr_bank, 1'b0);
    exp_idx = 0;
    pix_line("c_f3l0", 4, 1'b1, 1'b0);
    pix_line("c_f3l1", 4, 1'b1, 1'b0);
    vs_pulse();
    chk1("c_f3_done", frame_done, 1'b1);
    chk1("c_f3_rdb", rd_bank, 1'b0);
    chk16("c_f3_cnt", frame_cnt, 16'd3);
    cap_stop = 1'b1;
    tick();
    cap_stop = 1'b0;
    chk1("c_stop_busy", busy, 1'b0);

    // Short first line.
    do_reset();
    start(1'b0);
    vs_pulse();
    exp_idx = 0;
    pix_line("s_l0", 3, 1'b1, 1'b0);
    pix_line("s_l1", 4, 1'b1, 1'b0);
    vs_pulse();
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
    chk1("s_err", frame_err, 1'b1);
    chk1("s_done", frame_done, 1'b0);
    chk16("s_cnt", frame_cnt, 16'd0);
`else
    chk1("s_err", frame_err, 1'b0);
    chk1("s_done", frame_done, 1'b1);
    chk16("s_cnt", frame_cnt, 16'd1);
`endif
    tick();
    chk1("s_busy", busy, 1'b0);
    chk1("s_err_off", frame_err, 1'b0);
    start(1'b0);
    vs_pulse();
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
    chk1("s_next_bank", wr_bank, 1'b0);
`else
    chk1("s_next_bank", wr_bank, 1'b1);
`endif
    cap_stop = 1'b1;
    tick();
    cap_stop = 1'b0;

    // Nine pixels into an eight-pixel frame.
    do_reset();
    start(1'b0);
    vs_pulse();
    exp_idx = 0;
    pix_line("o_l0", 4, 1'b1, 1'b0);
    pix_line("o_l1", 5, 1'b1, 1'b0);
    vs_pulse();
`ifdef CMOS_FRAME_CTRL_ERR_CHK_EN
    chk1("o_err", frame_err, 1'b1);
    chk1("o_done", frame_done, 1'b0);
    chk16("o_cnt", frame_cnt, 16'd0);
`else
    chk1("o_err", frame_err, 1'b0);
    chk1("o_done", frame_done, 1'b1);
    chk16("o_cnt", frame_cnt, 16'd1);
`endif
    tick();

    // cap_stop mid-frame.
    do_reset();
    start(1'b0);
    vs_pulse();
    exp_idx = 0;
    pix_line("p_l0", 3, 1'b1, 1'b0);
    cap_stop = 1'b1;
    tick();
    cap_stop = 1'b0;
    chk1("p_busy", busy, 1'b0);
    chk1("p_done", frame_done, 1'b0);
    chk1("p_err", frame_err, 1'b0);
    pix_line("p_after", 4, 1'b0, 1'b0);
    vs_pulse();
    chk1("p_vs_done", frame_done, 1'b0);
    chk1("p_vs_err", frame_err, 1'b0);
    chk1("p_vs_busy", busy, 1'b0);

    // Reset while capturing into bank 1 with bank 0 published and owned by the reader.
    do_reset();
    start(1'b0);
    vs_pulse();
    exp_idx = 0;
    pix_line("r_f1l0", 4, 1'b1, 1'b0);
    pix_line("r_f1l1", 4, 1'b1, 1'b0);
    vs_pulse();
    chk1("r_f1_done", frame_done, 1'b1);
    tick();
    start(1'b0);
    vs_pulse();
    chk1("r_f2_bank", wr_bank, 1'b1);
    exp_idx = 0;
    pix_line("r_f2l0", 2, 1'b1, 1'b1);
    do_reset();
    chk_reset("rst_mid");
    start(1'b0);
    vs_pulse();
    chk1("r_f3_bank", wr_bank, 1'b0);
    exp_idx = 0;
    pix_line("r_f3l0", 1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmos_frame_ctrl.md
# cmos_frame_ctrl

Frame-level capture controller on the camera pixel clock. It sits between the 8-to-16-bit capture stage and the frame-buffer writer. It arms and stops capture, aligns to frame boundaries, and generates per-pixel write addresses. It also manages a two-bank ping-pong frame buffer with reader release, and publishes only complete, size-checked frames to the downstream reader (plate-recognition pipeline).

## Interface
Parameters:
- H_PIXEL, 640, active pixels per line
- V_PIXEL, 480, active lines per frame
- ADDR_W, 19, write address width; must satisfy H_PIXEL*V_PIXEL <= 2^ADDR_W

Ports (one clock, `cam_pclk`; reset `rst` is synchronous and active-high):
- cam_pclk  in  1  pixel clock, sole clock
- rst  in  1  synchronous active-high reset
- cap_start  in  1  pulse: arm capture (ignored unless IDLE)
- cap_mode  in  1  sampled with cap_start: 0 single frame, 1 continuous
- cap_stop  in  1  pulse: abort/stop, any state
- cmos_frame_vsync  in  1  frame sync from capture stage
- cmos_frame_href  in  1  line valid
- cmos_frame_valid  in  1  16-bit pixel strobe
- cmos_frame_data  in  16  RGB565 pixel
- rd_release  in  1  pulse: reader frees bank rd_rel_bank
- rd_rel_bank  in  1  bank being released
- wr_en  out  1  pixel write strobe
- wr_addr  out  ADDR_W  pixel index within bank, 0..H*V-1
- wr_data  out  16  pixel
- wr_bank  out  1  bank being written
- frame_done  out  1  one-cycle pulse: frame published
- rd_bank  out  1  most recently published bank
- busy  out  1  high in any state but IDLE
- frame_err  out  1  one-cycle pulse: frame discarded as malformed
- frame_cnt  out  16  published frame count, wraps 0xFFFF->0

## Operation
- Reset values:
  - wr_en/frame_done/frame_err/busy = 0
  - wr_addr = 0, wr_data = 0, wr_bank = 0
  - rd_bank = 1, frame_cnt = 0
  - bank_busy[1:0] = 00, state IDLE
- Frame boundary: rising edge of cmos_frame_vsync (vsync=1, registered vsync=0).
- States:
  - IDLE: cap_start -> ARM; latch mode.
  - ARM: on vsync edge -> CAPT with wr_bank=~rd_bank, addr/line counters cleared. If bank_busy[~rd_bank] is set at the edge -> HOLD instead.
  - CAPT: each cmos_frame_valid writes to wr_addr, then wr_addr increments. A pixel at index >= H*V is not written and sets the overflow flag. Each href falling edge checks the line pixel count == H_PIXEL and increments the line count. The next vsync edge -> END.
  - END (1 cycle): frame is good if all lines were correct, the line count == V_PIXEL and there was no overflow.
    - Good: frame_done=1, rd_bank<=wr_bank, bank_busy[wr_bank]<=1, frame_cnt++.
    - Bad: frame_err=1, bank not published.
    - Next state: single mode -> IDLE; continuous -> re-evaluate as at the ARM edge (same boundary starts next frame: CAPT or HOLD).
  - HOLD: no writes. On rd_release freeing ~rd_bank -> ARM (waits for next boundary; current frame dropped).
- rd_release clears bank_busy[rd_rel_bank]. The same-cycle publish sets the other bank; there is no conflict. Releasing an already-free bank has no effect.
- cap_stop: any state -> IDLE next cycle. The frame in progress is discarded: no frame_done, no frame_err. cap_stop beats cap_start in the same cycle.
- Pixels arriving outside CAPT are ignored.

## Timing
- wr_en/wr_addr/wr_data/wr_bank are registered: 1 cycle after cmos_frame_valid.
- Vsync edge sampled in cycle N -> END in N+1 -> frame_done/frame_err high for exactly cycle N+1. rd_bank and frame_cnt update in the same cycle.
- The first pixel of the next frame may arrive no earlier than N+2; this is guaranteed by vsync blanking.
- busy falls the cycle after END (single mode) or after cap_stop.
- rst mid-frame: all outputs at reset values the cycle after rst is sampled; bank ownership cleared.

## Configuration
- CMOS_FRAME_CTRL_ERR_CHK_EN defined: line-length, line-count and overflow checking as above; malformed frames discarded with frame_err.
- Not defined:
  - no line counting;
  - every frame reaching END is published;
  - frame_err tied 0.
  - Writes at index >= H*V are still suppressed.

## Test plan
- H=4,V=2, single mode: start, vsync edge, 2 lines x 4 pixels, vsync edge -> wr_addr 0..7 on bank 0; frame_done 1 cycle; rd_bank=0; frame_cnt=1; busy=0 next cycle.
- Continuous, no releases: frame 1 -> bank 0, frame 2 -> bank 1, frame 3 -> HOLD with no wr_en. rd_release(rd_rel_bank=0) -> next frame written and published on bank 0.
- Line 0 with 3 pixels (ERR_CHK_EN) -> frame_err pulse, no frame_done, frame_cnt unchanged; next frame uses the same wr_bank.
- 9 pixels in 4x2 frame -> 9th pixel no wr_en, frame_err pulse. Without the macro: frame_done, addresses 0..7 only.
- cap_stop after 3 pixels -> busy=0 next cycle; no frame_done/frame_err; later pixels not written.
- rst asserted mid-CAPT with bank 0 busy -> all outputs at reset values; next start writes bank 0.
